alu_seq_pipe: RTL
=================

Name: alu_seq_pipe

Overview:
Parametrised, registered successor to the generated combinational ALUs. It takes operands through a valid/ready input handshake and returns a registered result plus flags through a valid/ready output handshake. Single-cycle ops complete in one cycle. MUL runs on an iterative shift-add unit in WIDTH cycles, and full-width MUL overflow detection is added. It sits between an operand-issue stage and a writeback stage that may apply backpressure.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4, power of two)
SHIFT_W, $clog2(WIDTH), width of shiftValue

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
inValid  input  1  operand bundle valid
inReady  output  1  block can accept a bundle this cycle
opcode  input  4  operation select (map below)
input1  input  WIDTH  operand A
input2  input  WIDTH  operand B
shiftValue  input  SHIFT_W  shift/rotate amount
outValid  output  1  result bundle valid
outReady  input  1  consumer accepts result this cycle
result  output  WIDTH  registered result
carryFlag  output  1  carry (ADD) / borrow (SUB), else 0
zeroFlag  output  1  result == 0
overFlowFlag  output  1  signed overflow (ADD/SUB), unsigned high-half nonzero (MUL), else 0
illegalOp  output  1  opcode 13..15 was issued

Behaviour:
- Opcode map: XOR=0, SUB=1, SLL=2, MAX=3, MUL=4, ADD=5, ROL=6, AND=7, PASSB=8, ROR=9, SEQ=10, SRL=11, OR=12. Opcodes 13..15 are illegal.
- Reset (async, rst_n=0): result=0, all flags=0, outValid=0, illegalOp=0, FSM=IDLE, multiplier cleared. After reset release, inReady=1.
- FSM states:
  - IDLE: accept when inValid && inReady. A non-MUL op moves to HOLD; MUL moves to MUL_BUSY.
  - MUL_BUSY: counter runs WIDTH iterations, then moves to HOLD.
  - HOLD: outValid=1. On outReady, return to IDLE, or accept a new bundle in the same cycle.
- inReady = (state==IDLE) || (state==HOLD && outReady). It is combinational from outReady; there is no combinational path from inValid.
- Operands are captured on accept. Later input changes do not affect an op in flight.
- Latency: non-MUL, outValid rises on the edge after accept (1 cycle). MUL, outValid rises WIDTH+1 edges after accept.
- While outValid=1 && outReady=0, result and all flags hold stable.
- Arithmetic:
  - ADD/SUB: WIDTH+1-bit internal sum. carryFlag = bit WIDTH for ADD; for SUB it is borrow (input1 < input2, unsigned).
  - Overflow: ADD, operands same sign and result sign differs. SUB, operands differ in sign and result sign differs from input1.
  - MUL: result = low WIDTH bits of the unsigned product. overFlowFlag = high WIDTH bits != 0.
  - MAX: unsigned compare; input2 is returned on a tie.
  - SEQ: result = {WIDTH-1 zeros, (input1==input2)}.
  - SLL/SRL: logical shifts by shiftValue. ROL/ROR: rotate by shiftValue modulo WIDTH; shift 0 is identity.
- Illegal opcode: result=0, zeroFlag=1, illegalOp=1, 1-cycle latency. illegalOp is cleared on the next accepted bundle.
- zeroFlag is computed from the final registered result for every op, including MUL.
- Reset mid-MUL aborts the op with no output beat.

Decomposition:
- Package alu_pkg: opcode localparams/enum (4-bit), FSM state enum (IDLE, MUL_BUSY, HOLD), and a function is_illegal(opcode).
- Sub-module alu_seq_mul(WIDTH): iterative shift-add, unsigned, 2*WIDTH-bit product.
  - Ports: clk, rst_n, start, a, b, busy, done (1-cycle pulse), product.
  - done asserts exactly WIDTH cycles after start.
- The top holds the FSM, output register, flag logic and single-cycle datapath.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overFlowFlag=1, carryFlag=0, zeroFlag=0; outValid exactly 1 cycle after accept. ADD 0xFFFFFFFF + 1 -> result 0, carryFlag=1, zeroFlag=1, overFlowFlag=0.
2. SUB 5 - 7 -> 0xFFFFFFFE, carryFlag=1, overFlowFlag=0. SUB 0x80000000 - 1 -> 0x7FFFFFFF, overFlowFlag=1. SEQ 3,3 -> result 1, zeroFlag=0.
3. MUL 0x00010000 * 0x00010000 -> result 0, overFlowFlag=1, zeroFlag=1; outValid 33 cycles after accept, inReady=0 throughout. MUL 1234 * 5678 -> 7006652, overFlowFlag=0.
4. ROR 0x00000001 by 1 -> 0x80000000. ROL 0xA5A5A5A5 by 0 -> unchanged. SLL 1 by 31 -> 0x80000000. SRL 0x80000000 by 31 -> 1. Opcode 14 -> result 0, illegalOp=1.
5. Backpressure:
   - Hold outReady=0 for 5 cycles with inValid=1 -> result and flags stable, inReady=0, no accept.
   - Raise outReady -> drain and next accept in the same cycle, back-to-back beats with no bubble.
6. Reset mid-op:
   - Assert rst_n=0 at cycle 10 of a MUL -> all outputs 0 immediately.
   - After release -> inReady=1, no stale outValid.
   - Rerun scenarios 1 and 4 at WIDTH=8 (e.g. ADD 0x7F+1 -> 0x80, overFlowFlag=1).

Source files
------------

// File: rtl/alu_seq_pipe_pkg.sv
// alu_seq_pipe shared types
// opcode map, fsm states, small helpers
package alu_pkg;

  typedef enum logic [3:0] {
    OP_XOR   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_MAX   = 4'd3,
    OP_MUL   = 4'd4,
    OP_ADD   = 4'd5,
    OP_ROL   = 4'd6,
    OP_AND   = 4'd7,
    OP_PASSB = 4'd8,
    OP_ROR   = 4'd9,
    OP_SEQ   = 4'd10,
    OP_SRL   = 4'd11,
    OP_OR    = 4'd12
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    HOLD
  } state_t;

  typedef struct packed {
    logic carry;
    logic over;
  } flags_t;

  function automatic logic is_illegal(logic [3:0] op);
    return op > 4'd12;
  endfunction

endpackage

// File: rtl/alu_seq_pipe_if.sv
// alu_seq_pipe operand/result handshake bundle
// master = issue/writeback side, slave = alu
interface alu_seq_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
);
  logic               inValid;
  logic               inReady;
  logic [3:0]         opcode;
  logic [WIDTH-1:0]   input1;
  logic [WIDTH-1:0]   input2;
  logic [SHIFT_W-1:0] shiftValue;
  logic               outValid;
  logic               outReady;
  logic [WIDTH-1:0]   result;
  logic               carryFlag;
  logic               zeroFlag;
  logic               overFlowFlag;
  logic               illegalOp;

  modport master (
    output inValid, opcode, input1, input2,
    output shiftValue, outReady,
    input  inReady, outValid, result,
    input  carryFlag, zeroFlag,
    input  overFlowFlag, illegalOp
  );

  modport slave (
    input  inValid, opcode, input1, input2,
    input  shiftValue, outReady,
    output inReady, outValid, result,
    output carryFlag, zeroFlag,
    output overFlowFlag, illegalOp
  );
endinterface

// File: rtl/alu_seq_pipe_mul.sv
// iterative unsigned shift-add multiplier
// first partial product is taken on the start edge
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // one partial product per cycle, done pulses after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand  <= {{WIDTH{1'b0}}, a} << 1;
        mplier <= b >> 1;
        cnt    <= CW'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;
endmodule

// File: rtl/alu_seq_pipe.sv
// registered alu with valid/ready in and out
// single-cycle ops plus iterative multiply
module alu_seq_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rst_n,
  alu_seq_pipe_if.slave bus
);
  import alu_pkg::*;

  state_t             state;
  logic [WIDTH-1:0]   res_q;
  flags_t             flg_q;
  logic               zero_q;
  logic               vld_q;
  logic               ill_q;

  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHIFT_W-1:0] sh;
  logic [3:0]         op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flg;

  assign op_a = bus.input1;
  assign op_b = bus.input2;
  assign sh   = bus.shiftValue;
  assign op   = bus.opcode;

  assign in_ready = (state == IDLE && !mul_busy)
                 || (state == HOLD && bus.outReady);
  assign accept   = bus.inValid && in_ready;
  assign is_mul   = op == OP_MUL;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (prod)
  );

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  // single-cycle datapath, evaluated on the live operands at accept
  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    unique case (1'b1)
      op == OP_XOR:   alu_res = op_a ^ op_b;
      op == OP_AND:   alu_res = op_a & op_b;
      op == OP_OR:    alu_res = op_a | op_b;
      op == OP_PASSB: alu_res = op_b;
      op == OP_MAX:   alu_res = (op_a > op_b) ? op_a : op_b;
      op == OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, op_a == op_b};
      op == OP_SLL:   alu_res = op_a << sh;
      op == OP_SRL:   alu_res = op_a >> sh;
      op == OP_ROL:
        alu_res = (op_a << sh) | (op_a >> (WIDTH - int'(sh)));
      op == OP_ROR:
        alu_res = (op_a >> sh) | (op_a << (WIDTH - int'(sh)));
      op == OP_ADD: begin
        alu_res       = sum[WIDTH-1:0];
        alu_flg.carry = sum[WIDTH];
        alu_flg.over  = (op_a[WIDTH-1] == op_b[WIDTH-1])
                     && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      op == OP_SUB: begin
        alu_res       = diff[WIDTH-1:0];
        alu_flg.carry = diff[WIDTH];
        alu_flg.over  = (op_a[WIDTH-1] != op_b[WIDTH-1])
                     && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      default: alu_res = '0;
    endcase
  end

  // control fsm with the output register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      res_q  <= '0;
      flg_q  <= '0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (state == HOLD && bus.outReady) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
          if (accept) begin
            ill_q <= is_illegal(op);
            if (is_mul) begin
              vld_q <= 1'b0;
              state <= MUL_BUSY;
            end else begin
              vld_q  <= 1'b1;
              state  <= HOLD;
              res_q  <= alu_res;
              flg_q  <= alu_flg;
              zero_q <= alu_res == '0;
            end
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            vld_q       <= 1'b1;
            state       <= HOLD;
            res_q       <= prod[WIDTH-1:0];
            flg_q.carry <= 1'b0;
            flg_q.over  <= |prod[2*WIDTH-1:WIDTH];
            zero_q      <= prod[WIDTH-1:0] == '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inReady      = in_ready;
  assign bus.outValid     = vld_q;
  assign bus.result       = res_q;
  assign bus.carryFlag    = flg_q.carry;
  assign bus.overFlowFlag = flg_q.over;
  assign bus.zeroFlag     = zero_q;
  assign bus.illegalOp    = ill_q;
endmodule
